cr_cceip_64_sa_poller: RTL and testbench

- Register-bus initiator: the reading end of the 64-counter statistics-aggregator register interface.
- On a start pulse it writes the SA control register to snapshot (optionally clear) the live counters.
- It then reads all snapshot counters as lo/hi 32-bit words and emits one 50-bit record per counter on a valid/ready stream.
- Sits in the management/telemetry path between the SA register file and a DMA or host-push engine.

---
 rtl/cr_cceip_64_sa_poller_if.sv | 32 +++
 rtl/cr_cceip_64_sa_poller.sv | 226 ++++++++++++++++++++++
 tb/tb_cr_cceip_64_sa_poller.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cr_cceip_64_sa_poller_if.sv
// Register-bus request/completion channel and counter-record stream between the SA
// poller (master) and its register-file / record-sink peers (slave).
interface cr_cceip_64_sa_poller_if #(
    parameter int ADDR_W = 20
);
    logic              req_valid;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              req_ack;
    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic              rec_valid;
    logic              rec_ready;
    logic [5:0]        rec_idx;
    logic [49:0]       rec_count;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  req_ack, rsp_valid, rsp_data, rsp_err,
        output rec_valid, rec_idx, rec_count,
        input  rec_ready
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output req_ack, rsp_valid, rsp_data, rsp_err,
        input  rec_valid, rec_idx, rec_count,
        output rec_ready
    );
endinterface

// File: rtl/cr_cceip_64_sa_poller.sv
// Statistics-aggregator poller: snapshots the SA counters via a control write, then
// reads each snapshot as lo/hi words and streams one 50-bit record per counter.
module cr_cceip_64_sa_poller #(
    parameter int ADDR_W   = 20,
    parameter int N_CNT    = 64,
    parameter int CTRL_OFS = 'h000,
    parameter int SNAP_OFS = 'h100,
    parameter int TIMEOUT  = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    clear_live,
    input  logic [ADDR_W-1:0]       cfg_base_addr,
    cr_cceip_64_sa_poller_if.master bus,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] SNAP_REQ = 4'd1;
    localparam logic [3:0] SNAP_RSP = 4'd2;
    localparam logic [3:0] LO_REQ   = 4'd3;
    localparam logic [3:0] LO_RSP   = 4'd4;
    localparam logic [3:0] HI_REQ   = 4'd5;
    localparam logic [3:0] HI_RSP   = 4'd6;
    localparam logic [3:0] EMIT     = 4'd7;
    localparam logic [3:0] FIN      = 4'd8;

    localparam logic [ADDR_W-1:0] CTRL_A   = ADDR_W'(CTRL_OFS);
    localparam logic [ADDR_W-1:0] SNAP_A   = ADDR_W'(SNAP_OFS);
    localparam logic [7:0]        TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [5:0]        IDX_LAST = 6'(N_CNT - 1);

    logic [3:0]        state;
    logic [5:0]        idx;
    logic [7:0]        tcnt;
    logic [ADDR_W-1:0] base_q;
    logic              clr_q;
    logic [31:0]       lo_q;
    logic [17:0]       hi_q;
    logic              err_q;

    logic              tmo_hit;
    logic [ADDR_W-1:0] lo_addr;
    logic [ADDR_W-1:0] hi_addr;

    // The waiting cycle that would be the TIMEOUT-th without the awaited event aborts.
    assign tmo_hit = (tcnt == TMO_LAST);
    assign lo_addr = base_q + SNAP_A + ADDR_W'({idx, 3'b000});
    assign hi_addr = lo_addr + ADDR_W'(4);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            tcnt   <= '0;
            base_q <= '0;
            clr_q  <= 1'b0;
            lo_q   <= '0;
            hi_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q <= cfg_base_addr;
                        clr_q  <= clear_live;
                        err_q  <= 1'b0;
                        tcnt   <= '0;
                        idx    <= '0;
                        state  <= SNAP_REQ;
                    end
                end
                SNAP_REQ: begin
                    if (bus.req_ack) begin
                        tcnt  <= '0;
                        state <= SNAP_RSP;
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                        state <= FIN;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                SNAP_RSP: begin
                    if (bus.rsp_valid) begin
                        tcnt <= '0;
                        if (bus.rsp_err) begin
                            err_q <= 1'b1;
                            state <= FIN;
                        end else begin
                            idx   <= '0;
                            state <= LO_REQ;
                        end
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                        state <= FIN;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                LO_REQ: begin
                    if (bus.req_ack) begin
                        tcnt  <= '0;
                        state <= LO_RSP;
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                        state <= FIN;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                LO_RSP: begin
                    if (bus.rsp_valid) begin
                        tcnt <= '0;
                        if (bus.rsp_err) begin
                            err_q <= 1'b1;
                            state <= FIN;
                        end else begin
                            lo_q  <= bus.rsp_data;
                            state <= HI_REQ;
                        end
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                        state <= FIN;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                HI_REQ: begin
                    if (bus.req_ack) begin
                        tcnt  <= '0;
                        state <= HI_RSP;
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                        state <= FIN;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                HI_RSP: begin
                    if (bus.rsp_valid) begin
                        tcnt <= '0;
                        if (bus.rsp_err) begin
                            err_q <= 1'b1;
                            state <= FIN;
                        end else begin
                            hi_q  <= bus.rsp_data[17:0];
                            state <= EMIT;
                        end
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                        state <= FIN;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                // Backpressure here is unbounded: no timeout while the record waits.
                EMIT: begin
                    if (bus.rec_ready) begin
                        if (idx == IDX_LAST) begin
                            state <= FIN;
                        end else begin
                            idx   <= idx + 6'd1;
                            state <= LO_REQ;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic              req_valid_c;
    logic              req_wr_c;
    logic [ADDR_W-1:0] req_addr_c;
    logic [31:0]       req_wdata_c;

    // Request fields come straight from held state, so they stay stable until acked.
    always_comb begin
        req_valid_c = 1'b0;
        req_wr_c    = 1'b0;
        req_addr_c  = '0;
        req_wdata_c = '0;
        case (state)
            SNAP_REQ: begin
                req_valid_c = 1'b1;
                req_wr_c    = 1'b1;
                req_addr_c  = base_q + CTRL_A;
                req_wdata_c = {30'b0, clr_q, 1'b1};
            end
            LO_REQ: begin
                req_valid_c = 1'b1;
                req_addr_c  = lo_addr;
            end
            HI_REQ: begin
                req_valid_c = 1'b1;
                req_addr_c  = hi_addr;
            end
            default: begin
                req_valid_c = 1'b0;
            end
        endcase
    end

    assign bus.req_valid = req_valid_c;
    assign bus.req_wr    = req_wr_c;
    assign bus.req_addr  = req_addr_c;
    assign bus.req_wdata = req_wdata_c;

    assign bus.rec_valid = (state == EMIT);
    assign bus.rec_idx   = idx;
    assign bus.rec_count = {hi_q, lo_q};

    assign busy = (state != IDLE);
    assign done = (state == FIN);
    assign err  = err_q;

endmodule

// File: tb/tb_cr_cceip_64_sa_poller.sv
// Directed bench for the SA poller: a register-file responder with fixed ack/completion
// latency plus a record sink with scripted backpressure.
module tb_cr_cceip_64_sa_poller;
    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              clear_live;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic              busy;
    logic              done;
    logic              err;

    cr_cceip_64_sa_poller_if #(.ADDR_W(ADDR_W)) bus_if ();

    cr_cceip_64_sa_poller #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .clear_live    (clear_live),
        .cfg_base_addr (cfg_base_addr),
        .bus           (bus_if),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // responder / sink knobs
    bit                ack_wr_en;
    bit                ack_rd_en;
    bit                err_en;
    logic [ADDR_W-1:0] err_addr;
    logic [ADDR_W-1:0] cur_base;
    logic [31:0]       lo_base;
    logic [31:0]       hi_word;
    int                stall_idx;
    int                stall_left;

    // logs
    logic [ADDR_W-1:0] req_addr_log [0:299];
    logic              req_wr_log   [0:299];
    logic [31:0]       req_wd_log   [0:299];
    logic [5:0]        rec_idx_log  [0:99];
    logic [49:0]       rec_cnt_log  [0:99];
    int                n_req;
    int                n_rec;
    int                n_done;
    int                stall_cycles_seen;
    bit                stall_unstable;
    bit                stall_req_seen;
    logic [49:0]       stall_ref;

    function automatic logic [31:0] resp_data(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - cur_base - ADDR_W'('h100);
        if (off[2]) return hi_word;
        return lo_base + 32'(off >> 3);
    endfunction

    // Register file: ack in the request cycle, completion two cycles after the ack.
    initial begin
        bit                pend;
        int                cd;
        logic [ADDR_W-1:0] paddr;
        pend = 1'b0;
        cd = 0;
        paddr = '0;
        bus_if.req_ack = 1'b0;
        bus_if.rsp_valid = 1'b0;
        bus_if.rsp_data = '0;
        bus_if.rsp_err = 1'b0;
        bus_if.rec_ready = 1'b1;
        forever begin
            @(negedge clk);
            bus_if.req_ack = 1'b0;
            bus_if.rsp_valid = 1'b0;
            bus_if.rsp_data = '0;
            bus_if.rsp_err = 1'b0;
            bus_if.rec_ready = 1'b1;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    cd--;
                    if (cd == 0) begin
                        bus_if.rsp_valid = 1'b1;
                        bus_if.rsp_err = err_en && (paddr == err_addr);
                        bus_if.rsp_data = resp_data(paddr);
                        pend = 1'b0;
                    end
                end else if (bus_if.req_valid && (bus_if.req_wr ? ack_wr_en : ack_rd_en)) begin
                    bus_if.req_ack = 1'b1;
                    pend = 1'b1;
                    cd = 2;
                    paddr = bus_if.req_addr;
                    if (n_req < 300) begin
                        req_addr_log[n_req] = bus_if.req_addr;
                        req_wr_log[n_req] = bus_if.req_wr;
                        req_wd_log[n_req] = bus_if.req_wdata;
                    end
                    n_req++;
                end
                if (bus_if.rec_valid) begin
                    if (stall_left > 0 && bus_if.rec_idx == 6'(stall_idx)) begin
                        bus_if.rec_ready = 1'b0;
                        if (stall_cycles_seen == 0) stall_ref = bus_if.rec_count;
                        else if (bus_if.rec_count !== stall_ref) stall_unstable = 1'b1;
                        if (bus_if.req_valid) stall_req_seen = 1'b1;
                        stall_cycles_seen++;
                        stall_left--;
                    end else begin
                        if (n_rec < 100) begin
                            rec_idx_log[n_rec] = bus_if.rec_idx;
                            rec_cnt_log[n_rec] = bus_if.rec_count;
                        end
                        n_rec++;
                    end
                end
                if (done) n_done++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        n_req = 0;
        n_rec = 0;
        n_done = 0;
        stall_left = 0;
        stall_cycles_seen = 0;
        stall_unstable = 1'b0;
        stall_req_seen = 1'b0;
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] base, input logic clr);
        cur_base = base;
        cfg_base_addr = base;
        clear_live = clr;
        start = 1'b1;
        tick();
        start = 1'b0;
        clear_live = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit ok);
        int n0;
        n0 = n_done;
        ok = 1'b0;
        for (int c = 0; c < max; c++) begin
            if (n_done != n0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [3:0] st;
        rst = 1'b1;
        tick();
        tick();
        st = {busy, done, err, bus_if.req_valid};
        checks++;
        if (st !== 4'b0 || bus_if.rec_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: got busy/done/err/req_valid=%b rec_valid=%b expected 0000 0", st, bus_if.rec_valid);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({bus_if.req_addr, bus_if.req_wdata, bus_if.rec_idx, bus_if.rec_count} !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got addr=%0h wdata=%0h idx=%0d count=%0h busy=%b expected all 0",
                     bus_if.req_addr, bus_if.req_wdata, bus_if.rec_idx, bus_if.rec_count, busy);
        end
    endtask

    task automatic test_basic_poll();
        bit ok;
        logic [ADDR_W-1:0] ea;
        clear_logs();
        lo_base = 32'h1000;
        hi_word = 32'h3;
        pulse_start(20'h04000, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy: got %b expected 1", busy);
        end
        wait_done(5000, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_done: got no done expected done within 5000 cycles");
        end
        tick();
        checks++;
        if (n_done !== 1 || err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_end: got done_count=%0d err=%b busy=%b expected 1 0 0", n_done, err, busy);
        end
        checks++;
        if (n_req !== 129 || req_wr_log[0] !== 1'b1 || req_addr_log[0] !== 20'h04000 || req_wd_log[0] !== 32'h1) begin
            failures++;
            $display("FAIL basic_snap: got n_req=%0d wr=%b addr=%0h wdata=%0h expected 129 1 4000 1",
                     n_req, req_wr_log[0], req_addr_log[0], req_wd_log[0]);
        end
        checks++;
        if (req_addr_log[1] !== 20'h04100 || req_addr_log[2] !== 20'h04104 ||
            req_addr_log[127] !== 20'h042F8 || req_addr_log[128] !== 20'h042FC) begin
            failures++;
            $display("FAIL basic_addr_ends: got %0h %0h %0h %0h expected 4100 4104 42f8 42fc",
                     req_addr_log[1], req_addr_log[2], req_addr_log[127], req_addr_log[128]);
        end
        for (int i = 0; i < 64; i++) begin
            ea = 20'h04100 + ADDR_W'(8 * i);
            checks++;
            if (req_wr_log[1 + 2 * i] !== 1'b0 || req_addr_log[1 + 2 * i] !== ea ||
                req_wr_log[2 + 2 * i] !== 1'b0 || req_addr_log[2 + 2 * i] !== ea + 20'h4) begin
                failures++;
                $display("FAIL basic_rd[%0d]: got lo=%0h hi=%0h expected lo=%0h hi=%0h",
                         i, req_addr_log[1 + 2 * i], req_addr_log[2 + 2 * i], ea, ea + 20'h4);
            end
        end
        checks++;
        if (n_rec !== 64) begin
            failures++;
            $display("FAIL basic_nrec: got %0d expected 64", n_rec);
        end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (rec_idx_log[i] !== 6'(i) || rec_cnt_log[i] !== {18'h3, 32'h1000 + 32'(i)}) begin
                failures++;
                $display("FAIL basic_rec[%0d]: got idx=%0d count=%0h expected idx=%0d count=%0h",
                         i, rec_idx_log[i], rec_cnt_log[i], i, {18'h3, 32'h1000 + 32'(i)});
            end
        end
    endtask

    task automatic test_clear_live();
        bit ok;
        clear_logs();
        lo_base = 32'hA5A5_0000;
        hi_word = 32'hFFFF_FFFF;
        pulse_start(20'hFFF00, 1'b1);
        wait_done(5000, ok);
        tick();
        checks++;
        if (!ok || n_rec !== 64 || err !== 1'b0) begin
            failures++;
            $display("FAIL clr_end: got done=%b n_rec=%0d err=%b expected 1 64 0", ok, n_rec, err);
        end
        checks++;
        if (req_addr_log[0] !== 20'hFFF00 || req_wd_log[0] !== 32'h3) begin
            failures++;
            $display("FAIL clr_snap: got addr=%0h wdata=%0h expected fff00 3", req_addr_log[0], req_wd_log[0]);
        end
        checks++;
        if (req_addr_log[1] !== 20'h00000 || req_addr_log[128] !== 20'h001FC) begin
            failures++;
            $display("FAIL clr_wrap: got %0h %0h expected 0 1fc", req_addr_log[1], req_addr_log[128]);
        end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (rec_idx_log[i] !== 6'(i) || rec_cnt_log[i] !== {18'h3FFFF, 32'hA5A5_0000 + 32'(i)}) begin
                failures++;
                $display("FAIL clr_rec[%0d]: got idx=%0d count=%0h expected idx=%0d count=%0h",
                         i, rec_idx_log[i], rec_cnt_log[i], i, {18'h3FFFF, 32'hA5A5_0000 + 32'(i)});
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_logs();
        lo_base = 32'h1000;
        hi_word = 32'h3;
        stall_idx = 5;
        stall_left = 20;
        pulse_start(20'h04000, 1'b0);
        wait_done(5000, ok);
        tick();
        checks++;
        if (!ok || n_rec !== 64 || n_req !== 129) begin
            failures++;
            $display("FAIL bp_end: got done=%b n_rec=%0d n_req=%0d expected 1 64 129", ok, n_rec, n_req);
        end
        checks++;
        if (stall_cycles_seen !== 20 || stall_unstable !== 1'b0 || stall_req_seen !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall: got cycles=%0d unstable=%b req_seen=%b expected 20 0 0",
                     stall_cycles_seen, stall_unstable, stall_req_seen);
        end
        checks++;
        if (stall_ref !== {18'h3, 32'h1005}) begin
            failures++;
            $display("FAIL bp_held_count: got %0h expected %0h", stall_ref, {18'h3, 32'h1005});
        end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (rec_idx_log[i] !== 6'(i) || rec_cnt_log[i] !== {18'h3, 32'h1000 + 32'(i)}) begin
                failures++;
                $display("FAIL bp_rec[%0d]: got idx=%0d count=%0h expected idx=%0d count=%0h",
                         i, rec_idx_log[i], rec_cnt_log[i], i, {18'h3, 32'h1000 + 32'(i)});
            end
        end
    endtask

    task automatic test_rsp_err();
        bit ok;
        clear_logs();
        lo_base = 32'h2000;
        hi_word = 32'h1;
        err_en = 1'b1;
        err_addr = 20'h04154;
        pulse_start(20'h04000, 1'b0);
        wait_done(5000, ok);
        tick();
        checks++;
        if (!ok || n_done !== 1 || err !== 1'b1) begin
            failures++;
            $display("FAIL err_abort: got done=%b done_count=%0d err=%b expected 1 1 1", ok, n_done, err);
        end
        checks++;
        if (n_rec !== 10 || n_req !== 23 || rec_idx_log[9] !== 6'd9 || rec_cnt_log[9] !== {18'h1, 32'h2009}) begin
            failures++;
            $display("FAIL err_partial: got n_rec=%0d n_req=%0d last_idx=%0d last_count=%0h expected 10 23 9 %0h",
                     n_rec, n_req, rec_idx_log[9], rec_cnt_log[9], {18'h1, 32'h2009});
        end
        err_en = 1'b0;
        clear_logs();
        pulse_start(20'h04000, 1'b0);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL err_clear: got err=%b busy=%b expected 0 1", err, busy);
        end
        wait_done(5000, ok);
        tick();
        checks++;
        if (!ok || n_rec !== 64 || err !== 1'b0 || rec_cnt_log[63] !== {18'h1, 32'h203F}) begin
            failures++;
            $display("FAIL err_recover: got done=%b n_rec=%0d err=%b count63=%0h expected 1 64 0 %0h",
                     ok, n_rec, err, rec_cnt_log[63], {18'h1, 32'h203F});
        end
    endtask

    task automatic test_timeout();
        bit got;
        int hv;
        clear_logs();
        ack_wr_en = 1'b0;
        pulse_start(20'h04000, 1'b0);
        got = 1'b0;
        hv = 0;
        for (int c = 0; c < 400; c++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (bus_if.req_valid) hv++;
            if (c == 50) begin
                cfg_base_addr = 20'h08000;
                clear_live = 1'b1;
                start = 1'b1;
            end
            if (c == 51) begin
                start = 1'b0;
                clear_live = 1'b0;
                checks++;
                if (bus_if.req_addr !== 20'h04000 || bus_if.req_wdata !== 32'h1 || busy !== 1'b1 || err !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_start: got addr=%0h wdata=%0h busy=%b err=%b expected 4000 1 1 0",
                             bus_if.req_addr, bus_if.req_wdata, busy, err);
                end
            end
            tick();
        end
        checks++;
        if (!got || hv !== 255) begin
            failures++;
            $display("FAIL tmo_cycles: got done=%b req_valid_cycles=%0d expected 1 255", got, hv);
        end
        tick();
        checks++;
        if (err !== 1'b1 || n_done !== 1 || busy !== 1'b0 || n_req !== 0) begin
            failures++;
            $display("FAIL tmo_end: got err=%b done_count=%0d busy=%b n_req=%0d expected 1 1 0 0",
                     err, n_done, busy, n_req);
        end
        ack_wr_en = 1'b1;
    endtask

    task automatic test_rst_mid_poll();
        bit got;
        clear_logs();
        ack_rd_en = 1'b0;
        pulse_start(20'h04000, 1'b1);
        got = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (bus_if.req_valid && !bus_if.req_wr) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        tick();
        tick();
        checks++;
        if (!got || busy !== 1'b1 || bus_if.req_valid !== 1'b1 || bus_if.req_addr !== 20'h04100) begin
            failures++;
            $display("FAIL rst_pre: got seen=%b busy=%b req_valid=%b addr=%0h expected 1 1 1 4100",
                     got, busy, bus_if.req_valid, bus_if.req_addr);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({busy, done, err, bus_if.req_valid, bus_if.req_wr, bus_if.req_addr, bus_if.req_wdata,
             bus_if.rec_valid, bus_if.rec_idx, bus_if.rec_count} !== '0) begin
            failures++;
            $display("FAIL rst_mid: got busy=%b done=%b err=%b req_valid=%b addr=%0h rec_valid=%b count=%0h expected all 0",
                     busy, done, err, bus_if.req_valid, bus_if.req_addr, bus_if.rec_valid, bus_if.rec_count);
        end
        rst = 1'b0;
        ack_rd_en = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || bus_if.req_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_idle: got busy=%b req_valid=%b expected 0 0", busy, bus_if.req_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        clear_live = 1'b0;
        cfg_base_addr = '0;
        ack_wr_en = 1'b1;
        ack_rd_en = 1'b1;
        err_en = 1'b0;
        err_addr = '0;
        cur_base = '0;
        lo_base = '0;
        hi_word = '0;
        stall_idx = 0;
        stall_ref = '0;
        clear_logs();
        test_reset();
        test_basic_poll();
        test_clear_live();
        test_backpressure();
        test_rsp_err();
        test_timeout();
        test_rst_mid_poll();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
